// File: rtl/interval_timer.sv
// interval_timer: prescaled up/down interval counter with wrap or one-shot terminal handling
module interval_timer #(
  parameter int WIDTH    = 5,
  parameter int PRESCALE = 50000000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             enable,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  input  logic [WIDTH-1:0] limit,
  input  logic             mode_down,
  input  logic             one_shot,
  output logic [WIDTH-1:0] count,
  output logic             tick,
  output logic             done,
  output logic             expired
);
  localparam int PS_W = PRESCALE > 1 ? $clog2(PRESCALE) : 1;
  localparam logic [PS_W-1:0] PS_MAX = PS_W'(PRESCALE - 1);
  logic [PS_W-1:0] ps;
  logic run, step, term;
  assign run  = enable && !expired;
  assign step = run && ps == PS_MAX;
  assign term = mode_down ? count == '0 : count >= limit;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      count   <= '0;
      ps      <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else if (clear || load) begin
      count   <= clear ? (mode_down ? limit : '0) : (load_value > limit ? limit : load_value);
      ps      <= '0;
      tick    <= 1'b0;
      done    <= 1'b0;
      expired <= 1'b0;
    end else begin
      tick <= step;
      done <= step && term;
      if (run) ps <= step ? '0 : ps + 1'b1;
      if (step && term && one_shot) expired <= 1'b1;
      if (step && !(term && one_shot))
        count <= term ? (mode_down ? limit : '0) : (mode_down ? count - 1'b1 : count + 1'b1);
    end
endmodule

// File: tb/tb_interval_timer.sv
// tb_interval_timer: scoreboard bench; stimulus queues expected per-tick results, monitor pops on each tick
module tb_interval_timer;
  logic clk = 1'b0, rst = 1'b0, clear = 1'b0, enable = 1'b0, load = 1'b0;
  logic mode_down = 1'b0, one_shot = 1'b0, enable1 = 1'b0;
  logic [4:0] load_value = '0, limit = 5'd23, limit1 = '0;
  logic [4:0] count, count1;
  logic tick, done, expired, tick1, done1, expired1;
  logic [6:0] q[$];
  int checks = 0, errors = 0;

  interval_timer #(.WIDTH(5), .PRESCALE(4)) dut (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable), .load(load),
    .load_value(load_value), .limit(limit), .mode_down(mode_down), .one_shot(one_shot),
    .count(count), .tick(tick), .done(done), .expired(expired));

  interval_timer #(.WIDTH(5), .PRESCALE(1)) dut1 (
    .clk(clk), .rst(rst), .clear(clear), .enable(enable1), .load(load),
    .load_value(load_value), .limit(limit1), .mode_down(mode_down), .one_shot(one_shot),
    .count(count1), .tick(tick1), .done(done1), .expired(expired1));

  always #5 clk = ~clk;

  task automatic push(input logic [4:0] c, input logic d, input logic e);
    q.push_back({c, d, e});
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, got, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  always @(negedge clk)
    if (rst && tick) begin
      logic [6:0] e;
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_tick: got count=%0d done=%0b expired=%0b expected no tick", count, done, expired);
      end else begin
        e = q.pop_front();
        if ({count, done, expired} !== e) begin
          errors++;
          $display("FAIL step: got count=%0d done=%0b expired=%0b expected count=%0d done=%0b expired=%0b",
                   count, done, expired, e[6:2], e[1], e[0]);
        end
      end
    end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc(3);
    chk("reset_state", {count, tick, done, expired}, 0);
    rst = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("hold_disabled", {count, tick, done, expired}, 0);
    end
    for (int i = 1; i <= 23; i++) push(5'(i), 1'b0, 1'b0);
    push(5'd0, 1'b1, 1'b0);
    enable = 1'b1;
    cyc(96);
    enable = 1'b0;
    cyc(2);
    chk("up_wrap_drain", q.size(), 0);
    chk("up_wrap_count", count, 0);
    for (int i = 1; i <= 10; i++) push(5'(i), 1'b0, 1'b0);
    enable = 1'b1;
    cyc(43);
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_collision", {count, tick, done}, 0);
    push(5'd1, 1'b0, 1'b0);
    cyc(3);
    chk("after_clear_wait", count, 0);
    cyc(1);
    chk("after_clear_step", count, 1);
    enable = 1'b0;
    cyc(1);
    chk("clear_drain", q.size(), 0);
    load_value = 5'd30;
    mode_down = 1'b1;
    one_shot = 1'b1;
    load = 1'b1;
    cyc(1);
    load = 1'b0;
    chk("load_clamp", {count, expired}, {5'd23, 1'b0});
    for (int i = 22; i >= 0; i--) push(5'(i), 1'b0, 1'b0);
    push(5'd0, 1'b1, 1'b1);
    enable = 1'b1;
    cyc(96);
    chk("one_shot_expired", {count, expired}, {5'd0, 1'b1});
    for (int i = 0; i < 20; i++) begin
      cyc(1);
      chk("expired_no_tick", {count, tick, done, expired}, {5'd0, 3'b001});
    end
    chk("one_shot_drain", q.size(), 0);
    enable = 1'b0;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_down_reload", {count, expired}, {5'd23, 1'b0});
    mode_down = 1'b0;
    one_shot = 1'b0;
    clear = 1'b1;
    cyc(1);
    clear = 1'b0;
    chk("clear_up", count, 0);
    enable1 = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cyc(1);
      chk("ps1_limit0", {count1, tick1, done1}, 7'b0000011);
    end
    enable1 = 1'b0;
    cyc(1);
    chk("ps1_paused", {tick1, done1}, 0);
    for (int i = 1; i <= 7; i++) push(5'(i), 1'b0, 1'b0);
    enable = 1'b1;
    cyc(30);
    chk("pre_async_count", count, 7);
    #2 rst = 1'b0;
    #1 chk("async_reset", {count, tick, done, expired}, 0);
    @(posedge clk);
    #1 rst = 1'b1;
    push(5'd1, 1'b0, 1'b0);
    cyc(3);
    chk("post_reset_wait", count, 0);
    cyc(1);
    chk("post_reset_step", count, 1);
    enable = 1'b0;
    cyc(2);
    chk("final_drain", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
